// File: rtl/ascon_perm_seq_if.sv
// Bus between the Ascon round sequencer and its surroundings: the mode FSM
// handshake plus the state path to and from the combinational round function.
interface ascon_perm_seq_if;
  logic              start_i;
  logic              mode_i;
  logic [4:0][63:0]  state_i;
  logic [4:0][63:0]  pcin_o;
  logic [4:0][63:0]  pcout_i;
  logic [3:0]        round_o;
  logic [4:0][63:0]  state_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output start_i, mode_i, state_i, pcout_i,
    input  pcin_o, round_o, state_o, busy_o, done_o
  );

  modport slave (
    input  start_i, mode_i, state_i, pcout_i,
    output pcin_o, round_o, state_o, busy_o, done_o
  );
endinterface

// File: rtl/ascon_perm_seq.sv
// Ascon permutation round sequencer: owns the 320-bit state, steps pc one round per clock.
// Optional macro ASCON_PERM_SEQ_ERR_EN adds a sticky err_o for start requests seen while running.
module ascon_perm_seq #(
  parameter int ROUNDS_A   = 12,
  parameter int ROUNDS_B   = 6,
  parameter int LAST_ROUND = 11
) (
  input  logic clock_i,
  input  logic reset_i,
  ascon_perm_seq_if.slave bus
`ifdef ASCON_PERM_SEQ_ERR_EN
  ,
  output logic err_o
`endif
);

  localparam logic [3:0] FIRST_A = 4'(LAST_ROUND + 1 - ROUNDS_A);
  localparam logic [3:0] FIRST_B = 4'(LAST_ROUND + 1 - ROUNDS_B);
  localparam logic [3:0] LAST_R  = 4'(LAST_ROUND);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e             fsm_q;
  logic [4:0][63:0] st_q;
  logic [3:0]       cnt_q;
  logic             busy_q;
  logic             done_q;

  // The counter returns to 0 on the last round, so round_o reads 0 outside RUN.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE, DONE: begin
          if (bus.start_i) begin
            st_q   <= bus.state_i;
            cnt_q  <= bus.mode_i ? FIRST_A : FIRST_B;
            busy_q <= 1'b1;
            fsm_q  <= RUN;
          end else begin
            busy_q <= 1'b0;
            fsm_q  <= IDLE;
          end
        end
        RUN: begin
          st_q <= bus.pcout_i;
          if (cnt_q == LAST_R) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            fsm_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          cnt_q  <= '0;
          busy_q <= 1'b0;
          fsm_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.pcin_o  = st_q;
  assign bus.state_o = st_q;
  assign bus.round_o = cnt_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

`ifdef ASCON_PERM_SEQ_ERR_EN
  logic err_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else if ((fsm_q == RUN) && bus.start_i) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_ascon_perm_seq.sv
// Bench for ascon_perm_seq: supplies an Ascon round model as pc and scoreboards each finished permutation.
module tb_ascon_perm_seq;
  typedef logic [4:0][63:0] st_t;
  typedef struct {
    st_t st;
    int  cyc;
  } exp_t;

  localparam st_t VA = {64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
                        64'h0011223344556677, 64'h8899aabbccddeeff};
  localparam st_t VB = {64'h598da474303d9164, 64'h7559456e06c73ad3, 64'h94beaba9335e44cd,
                        64'h8866d2abc492c960, 64'hc11bf1d12e77b520};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  ascon_perm_seq_if bus();

`ifdef ASCON_PERM_SEQ_ERR_EN
  logic err;
  ascon_perm_seq dut (.clock_i(clk), .reset_i(rst), .bus(bus), .err_o(err));
`else
  ascon_perm_seq dut (.clock_i(clk), .reset_i(rst), .bus(bus));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ror(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One Ascon round, x0 is the most significant word of the packed state.
  function automatic st_t ascon_round(st_t s, logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    st_t o;
    x0 = s[4]; x1 = s[3]; x2 = s[2]; x3 = s[1]; x4 = s[0];
    x2 = x2 ^ {56'h0, 4'hf - r, r};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    o[4] = x0; o[3] = x1; o[2] = x2; o[1] = x3; o[0] = x4;
    return o;
  endfunction

  function automatic st_t perm(st_t s, int first, int n);
    st_t t;
    t = s;
    for (int i = 0; i < n; i++) t = ascon_round(t, 4'(first + i));
    return t;
  endfunction

  assign bus.pcout_i = ascon_round(bus.pcin_o, bus.round_o);

  task automatic chk_st(string name, st_t act, st_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_n(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; start is sampled on the next rising edge.
  task automatic issue(st_t s, bit m);
    exp_t e;
    bus.start_i = 1'b1;
    bus.mode_i  = m;
    bus.state_i = s;
    @(posedge clk);
    #1;
    e.st  = m ? perm(s, 0, 12) : perm(s, 6, 6);
    e.cyc = cyc + (m ? 12 : 6);
    sb_q.push_back(e);
    bus.start_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: done_o=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk_st("done_state", bus.state_o, mon_e.st);
        chk_n("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    bus.start_i = 1'b0;
    bus.mode_i  = 1'b0;
    bus.state_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_st("rst_state", bus.state_o, '0);
      chk_n("rst_round", int'(bus.round_o), 0);
      chk_n("rst_busy", int'(bus.busy_o), 0);
      chk_n("rst_done", int'(bus.done_o), 0);
    end
`ifdef ASCON_PERM_SEQ_ERR_EN
    chk_n("rst_err", int'(err), 0);
`endif

    // p^a run
    @(negedge clk);
    issue(VA, 1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk_n("pa_round", int'(bus.round_o), k);
      chk_n("pa_busy", int'(bus.busy_o), 1);
    end
    @(negedge clk);
    chk_n("pa_done_busy", int'(bus.busy_o), 0);
    chk_n("pa_done_round", int'(bus.round_o), 0);
    repeat (3) @(negedge clk);
    chk_st("pa_hold", bus.state_o, perm(VA, 0, 12));
    chk_n("pa_hold_done", int'(bus.done_o), 0);

    // p^b run
    issue(VB, 1'b0);
    for (int k = 6; k < 12; k++) begin
      @(negedge clk);
      chk_n("pb_round", int'(bus.round_o), k);
    end
    repeat (4) @(negedge clk);
    chk_st("pb_hold", bus.state_o, perm(VB, 6, 6));

    // start while busy, at round 4
    issue(VA, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_n("busy_round", int'(bus.round_o), k);
    end
    @(negedge clk);
    chk_n("busy_round4", int'(bus.round_o), 4);
    bus.start_i = 1'b1;
    bus.mode_i  = 1'b0;
    bus.state_i = VB;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int k = 5; k < 12; k++) begin
      @(negedge clk);
      chk_n("busy_round", int'(bus.round_o), k);
    end
    @(negedge clk);
    chk_n("busy_done_flag", int'(bus.done_o), 1);
`ifdef ASCON_PERM_SEQ_ERR_EN
    chk_n("err_sticky", int'(err), 1);
`endif
    repeat (2) @(negedge clk);

    // back-to-back: second start in the DONE cycle
    issue(VB, 1'b0);
    for (int k = 6; k < 12; k++) begin
      @(negedge clk);
      chk_n("b2b_round1", int'(bus.round_o), k);
    end
    @(negedge clk);
    chk_n("b2b_done1", int'(bus.done_o), 1);
    chk_st("b2b_state1", bus.state_o, perm(VB, 6, 6));
    issue(VA, 1'b0);
    for (int k = 6; k < 12; k++) begin
      @(negedge clk);
      chk_n("b2b_round2", int'(bus.round_o), k);
    end
    repeat (3) @(negedge clk);
    chk_st("b2b_state2", bus.state_o, perm(VA, 6, 6));

    // reset mid-run at round 7
    issue(VB, 1'b1);
    for (int k = 0; k < 7; k++) @(negedge clk);
    @(negedge clk);
    chk_n("abort_round7", int'(bus.round_o), 7);
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_st("abort_state", bus.state_o, '0);
    chk_n("abort_round", int'(bus.round_o), 0);
    chk_n("abort_busy", int'(bus.busy_o), 0);
`ifdef ASCON_PERM_SEQ_ERR_EN
    chk_n("abort_err", int'(err), 0);
`endif
    repeat (20) @(negedge clk);
    chk_n("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
